// File: rtl/fetch_controller_if.sv
// rtl/fetch_controller_if.sv - icache, predictor, instruction-queue and ROB signals of the fetch controller
interface fetch_controller_if #(
    parameter int CNT_WIDTH = 32
);
    logic                 rdy_in;
    logic                 icache_req_valid;
    logic [31:0]          icache_req_addr;
    logic                 icache_resp_valid;
    logic [31:0]          icache_resp_inst;
    logic [31:0]          bp_pc;
    logic                 bp_taken;
    logic                 iq_full;
    logic                 inst_valid;
    logic [31:0]          inst_out;
    logic [31:0]          inst_pc;
    logic                 inst_pred_taken;
    logic                 jalr_resolve;
    logic [31:0]          jalr_target;
    logic                 rob_flush;
    logic [31:0]          rob_flush_pc;
    logic [CNT_WIDTH-1:0] stat_branch_cnt;
    logic [CNT_WIDTH-1:0] stat_flush_cnt;

    modport master (
        input  rdy_in, icache_resp_valid, icache_resp_inst, bp_taken, iq_full,
               jalr_resolve, jalr_target, rob_flush, rob_flush_pc,
        output icache_req_valid, icache_req_addr, bp_pc, inst_valid, inst_out,
               inst_pc, inst_pred_taken, stat_branch_cnt, stat_flush_cnt
    );

    modport slave (
        output rdy_in, icache_resp_valid, icache_resp_inst, bp_taken, iq_full,
               jalr_resolve, jalr_target, rob_flush, rob_flush_pc,
        input  icache_req_valid, icache_req_addr, bp_pc, inst_valid, inst_out,
               inst_pc, inst_pred_taken, stat_branch_cnt, stat_flush_cnt
    );
endinterface

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - fetch PC owner: one icache request at a time, predecode, next-PC select
module fetch_controller #(
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter int          CNT_WIDTH = 32
) (
    input  logic               clk_in,
    input  logic               rst_in,
    fetch_controller_if.master bus
);
    typedef enum logic [2:0] {IDLE, REQ, STALL_IQ, WAIT_JALR, DRAIN} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t               state;
    logic [31:0]          pc;
    logic                 req_valid_q;
    logic [31:0]          req_addr_q;
    logic                 inst_valid_q;
    logic [31:0]          inst_q;
    logic [31:0]          inst_pc_q;
    logic                 pred_q;
    logic [31:0]          lat_next;
    logic                 lat_jalr;
    logic [CNT_WIDTH-1:0] branch_cnt;
    logic [CNT_WIDTH-1:0] flush_cnt;

    logic [31:0] w;
    logic        is_jal, is_br, is_jalr, pred;
    logic [31:0] j_imm, b_imm, next_pc;

    assign w       = bus.icache_resp_inst;
    assign is_jal  = (w[6:0] == 7'b1101111);
    assign is_br   = (w[6:0] == 7'b1100011);
    assign is_jalr = (w[6:0] == 7'b1100111);
    assign pred    = is_br & bus.bp_taken;
    assign j_imm   = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    assign b_imm   = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    assign next_pc = is_jal ? pc + j_imm : (pred ? pc + b_imm : pc + 32'd4);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            req_valid_q  <= 1'b0;
            req_addr_q   <= 32'h0;
            inst_valid_q <= 1'b0;
            inst_q       <= 32'h0;
            inst_pc_q    <= 32'h0;
            pred_q       <= 1'b0;
            lat_next     <= 32'h0;
            lat_jalr     <= 1'b0;
            branch_cnt   <= '0;
            flush_cnt    <= '0;
        end else if (bus.rdy_in) begin
            inst_valid_q <= 1'b0;
            if (bus.rob_flush) begin
                flush_cnt   <= flush_cnt + CNT_ONE;
                pc          <= bus.rob_flush_pc;
                req_valid_q <= 1'b0;
                // Only an unanswered request leaves a response in flight that must be drained.
                if (((state == REQ) && req_valid_q) || (state == DRAIN))
                    state <= bus.icache_resp_valid ? REQ : DRAIN;
                else
                    state <= REQ;
            end else begin
                case (state)
                    IDLE: state <= REQ;
                    REQ: begin
                        if (!req_valid_q) begin
                            req_valid_q <= 1'b1;
                            req_addr_q  <= pc;
                        end else if (bus.icache_resp_valid) begin
                            req_valid_q <= 1'b0;
                            inst_q      <= w;
                            inst_pc_q   <= pc;
                            pred_q      <= pred;
                            if (is_br)
                                branch_cnt <= branch_cnt + CNT_ONE;
                            if (!bus.iq_full) begin
                                inst_valid_q <= 1'b1;
                                pc           <= next_pc;
                                state        <= is_jalr ? WAIT_JALR : REQ;
                            end else begin
                                lat_next <= next_pc;
                                lat_jalr <= is_jalr;
                                state    <= STALL_IQ;
                            end
                        end
                    end
                    STALL_IQ: begin
                        if (!bus.iq_full) begin
                            inst_valid_q <= 1'b1;
                            pc           <= lat_next;
                            state        <= lat_jalr ? WAIT_JALR : REQ;
                        end
                    end
                    WAIT_JALR: begin
                        if (bus.jalr_resolve) begin
                            pc    <= bus.jalr_target;
                            state <= REQ;
                        end
                    end
                    DRAIN: begin
                        if (bus.icache_resp_valid)
                            state <= REQ;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.icache_req_valid = req_valid_q;
    assign bus.icache_req_addr  = req_addr_q;
    assign bus.bp_pc            = req_addr_q;
    assign bus.inst_valid       = inst_valid_q;
    assign bus.inst_out         = inst_q;
    assign bus.inst_pc          = inst_pc_q;
    assign bus.inst_pred_taken  = pred_q;
    assign bus.stat_branch_cnt  = branch_cnt;
    assign bus.stat_flush_cnt   = flush_cnt;
endmodule
